axis_stim_gen: RTL and testbench
================================

AXIS_STIM_GEN -- requirements
Module: axis_stim_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bits per real/imag component; tdata is 2*WIDTH bits, {im, re}.
REQ-002 SHALL have parameter MAX_CNT, default 64: samples per frame (FFT_LEN of the downstream OSPFB), >= 2.
REQ-003 SHALL have parameter FRAME_WID, default 16: width of the frame counter, num_frames and tuser.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge (one clock, no CDC).
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port en  input  1  run request.
REQ-007 SHALL have port mode  input  2  pattern select: 0 IMPULSE, 1 STEP, 2 RAMP, 3 CONST.
REQ-008 SHALL have port pulse_val  input  WIDTH  signed amplitude.
REQ-009 SHALL have port impulse_phase  input  $clog2(MAX_CNT)+1  sample index of the impulse or step edge.
REQ-010 SHALL have port num_frames  input  FRAME_WID  frames per burst; 0 = continuous.
REQ-011 SHALL have port m_axis  axis.MST  2*WIDTH  output stream (tdata, tvalid, tready).
REQ-012 SHALL have port m_axis_tlast  output  1  last sample of each frame.
REQ-013 SHALL have port m_axis_tuser  output  FRAME_WID  frame index of the current sample.
REQ-014 SHALL have port busy  output  1  high in RUN.
REQ-015 SHALL have port done  output  1  high in DONE.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE; IDLE->RUN when en=1; RUN->DONE after the handshake of tlast in frame num_frames-1 (num_frames!=0); RUN->IDLE after the tlast handshake if en=0; DONE->IDLE when en=0.
REQ-017 SHALL latch mode, pulse_val, impulse_phase and num_frames on IDLE->RUN; input changes during RUN have no effect until the next burst.
REQ-018 SHALL assert tvalid in the cycle after the one where en is sampled high in IDLE, and keep tvalid high for the whole of RUN.
REQ-019 SHALL hold tdata, tlast and tuser stable while tvalid=1 and tready=0; the sample index s (0..MAX_CNT-1) and frame index f advance only on a handshake (tvalid & tready).
REQ-020 SHALL drive tlast=1 exactly when s==MAX_CNT-1; s wraps to 0 and f increments on that handshake.
REQ-021 SHALL let f wrap modulo 2^FRAME_WID in continuous mode with no other effect.
REQ-022 SHALL generate IMPULSE as re=pulse_val when s==impulse_phase, else 0; im=0.
REQ-023 SHALL generate STEP as re=pulse_val when s>=impulse_phase, else 0; im=0.
REQ-024 SHALL generate RAMP as re=s zero-extended to WIDTH and im=f truncated to WIDTH.
REQ-025 SHALL generate CONST as re=im=pulse_val.
REQ-026 SHALL produce an all-zero stream in IMPULSE and STEP when impulse_phase >= MAX_CNT.
REQ-027 SHALL, when en falls mid-frame, complete the current frame (frame-aligned stop); a partial frame is never emitted.
REQ-028 SHALL drive tvalid=0 in IDLE and DONE.

Reset
REQ-029 SHALL, while rst_n=0 (asynchronous, also in mid-burst), set state=IDLE, s=0, f=0, tvalid=0, tlast=0, tdata=0, tuser=0, busy=0, done=0.
REQ-030 SHALL start the first burst after reset release only on an en sampled high at a clock edge with rst_n=1.

Structure
REQ-031 SHALL place the mode enum (IMPULSE/STEP/RAMP/CONST) and the state enum (IDLE/RUN/DONE) in the shared package stim_pkg.
REQ-032 SHALL implement the s/f counters with tlast and frame-count detection in one sub-module, axis_frame_counter, parameterised by MAX_CNT and FRAME_WID.

Verification
REQ-033 SHALL cover: WIDTH=16, MAX_CNT=64, IMPULSE, pulse_val=64, phase=49, num_frames=3, tready=1 -> 192 beats, re=64 only at s=49, tlast at beats 63/127/191, tuser 0,1,2, done=1.
REQ-034 SHALL cover: RAMP with random tready (50%) -> tdata stable under stall, re=0..63 per frame, im=frame index, no lost or duplicated beats.
REQ-035 SHALL cover: STEP, phase=70 -> all-zero tdata; STEP, phase=0 -> re=pulse_val on every beat.
REQ-036 SHALL cover: continuous mode, en dropped at s=10 -> frame completes to s=63 with tlast, then tvalid=0, busy=0.
REQ-037 SHALL cover: rst_n pulsed low mid-frame (s=30) -> all outputs 0 immediately without waiting for clk; next burst restarts at s=0, tuser=0.
REQ-038 SHALL cover: mode/pulse_val changed during RUN -> output unchanged until the next IDLE->RUN.

Source files
------------

// File: rtl/stim_pkg.sv
// Shared enums for the AXI-Stream stimulus generator.
package stim_pkg;

  typedef enum logic [1:0] {
    IMPULSE = 2'd0,
    STEP    = 2'd1,
    RAMP    = 2'd2,
    CONST   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/axis_stim_gen_if.sv
// Minimal AXI-Stream bundle: payload plus valid/ready handshake.
interface axis #(
  parameter int DW = 32
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport MST (output tdata, output tvalid, input  tready);
  modport SLV (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/axis_frame_counter.sv
// Sample (s) and frame (f) counters; flags the last sample of a frame and
// the last sample of the last frame of a finite burst.
module axis_frame_counter #(
  parameter  int MAX_CNT   = 64,
  parameter  int FRAME_WID = 16,
  localparam int SW        = $clog2(MAX_CNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 adv,
  input  logic [FRAME_WID-1:0] num_frames,
  output logic [SW-1:0]        s,
  output logic [FRAME_WID-1:0] f,
  output logic                 last,
  output logic                 final_beat
);

  localparam logic [SW-1:0]        S_ONE  = SW'(1);
  localparam logic [SW-1:0]        S_LAST = SW'(MAX_CNT - 1);
  localparam logic [FRAME_WID-1:0] F_ONE  = FRAME_WID'(1);

  assign last       = (s == S_LAST);
  // num_frames == 0 means continuous, so there is never a final beat
  assign final_beat = last && (num_frames != '0) && (f == num_frames - F_ONE);

  // Counters move only on a handshake; f wraps naturally in continuous mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
      f <= '0;
    end else if (clr) begin
      s <= '0;
      f <= '0;
    end else if (adv) begin
      if (last) begin
        s <= '0;
        f <= f + F_ONE;
      end else begin
        s <= s + S_ONE;
      end
    end
  end

endmodule

// File: rtl/axis_stim_gen.sv
// Frame-aligned test-pattern source (impulse/step/ramp/const) on AXI-Stream.
// Payload is purely a function of latched config and the s/f counters, so it
// holds still for free while the sink stalls.
module axis_stim_gen
  import stim_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int MAX_CNT   = 64,
  parameter  int FRAME_WID = 16,
  localparam int SW        = $clog2(MAX_CNT),
  localparam int PW        = SW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     pulse_val,
  input  logic [PW-1:0]        impulse_phase,
  input  logic [FRAME_WID-1:0] num_frames,
  axis.MST                     m_axis,
  output logic                 m_axis_tlast,
  output logic [FRAME_WID-1:0] m_axis_tuser,
  output logic                 busy,
  output logic                 done
);

  state_e               state_q, state_d;
  mode_e                mode_q;
  logic [WIDTH-1:0]     pv_q;
  logic [PW-1:0]        phase_q;
  logic [FRAME_WID-1:0] nf_q;

  logic                 run, start, hs;
  logic [SW-1:0]        s;
  logic [FRAME_WID-1:0] f;
  logic                 last, final_beat;
  logic [WIDTH-1:0]     re, im;

  assign run   = (state_q == RUN);
  assign start = (state_q == IDLE) && en;
  assign hs    = run && m_axis.tready;

  axis_frame_counter #(
    .MAX_CNT   (MAX_CNT),
    .FRAME_WID (FRAME_WID)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start),
    .adv        (hs),
    .num_frames (nf_q),
    .s          (s),
    .f          (f),
    .last       (last),
    .final_beat (final_beat)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Burst config is captured once at start; later input changes wait for the next burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= IMPULSE;
      pv_q    <= '0;
      phase_q <= '0;
      nf_q    <= '0;
    end else if (start) begin
      mode_q  <= mode_e'(mode);
      pv_q    <= pulse_val;
      phase_q <= impulse_phase;
      nf_q    <= num_frames;
    end
  end

  // Next state: leave RUN only on a tlast handshake so frames are never cut short
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (en) state_d = RUN;
      RUN: begin
        if (hs && last) begin
          if (final_beat) state_d = DONE;
          else if (!en)   state_d = IDLE;
        end
      end
      DONE:    if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pattern generation; phase >= MAX_CNT never matches s, giving an all-zero stream
  always_comb begin
    re = '0;
    im = '0;
    if (run) begin
      case (mode_q)
        IMPULSE: if ({1'b0, s} == phase_q) re = pv_q;
        STEP:    if ({1'b0, s} >= phase_q) re = pv_q;
        RAMP: begin
          re = WIDTH'(s);
          im = WIDTH'(f);
        end
        CONST: begin
          re = pv_q;
          im = pv_q;
        end
        default: ;
      endcase
    end
  end

  assign m_axis.tdata  = {im, re};
  assign m_axis.tvalid = run;
  assign m_axis_tlast  = run && last;
  assign m_axis_tuser  = run ? f : '0;
  assign busy          = run;
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_axis_stim_gen.sv
// Scoreboarded bench for axis_stim_gen: a pattern model fills an expected-beat
// queue per burst, a monitor pops it on every handshake and checks stall hold.
module tb_axis_stim_gen;

  localparam int W  = 16;
  localparam int N  = 64;
  localparam int FW = 16;

  typedef struct packed {
    logic [2*W-1:0] data;
    logic           last;
    logic [FW-1:0]  user;
  } beat_t;

  typedef struct {
    int md; int pv; int ph; int nf; int rdy; int eb; int enz;
  } vec_t;

  logic          clk, rst_n, en;
  logic [1:0]    mode;
  logic [W-1:0]  pulse_val;
  logic [6:0]    impulse_phase;
  logic [FW-1:0] num_frames;
  logic          m_axis_tlast;
  logic [FW-1:0] m_axis_tuser;
  logic          busy, done;

  axis #(.DW(2*W)) m_axis ();

  axis_stim_gen #(.WIDTH(W), .MAX_CNT(N), .FRAME_WID(FW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .mode          (mode),
    .pulse_val     (pulse_val),
    .impulse_phase (impulse_phase),
    .num_frames    (num_frames),
    .m_axis        (m_axis),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .done          (done)
  );

  int    checks = 0;
  int    errors = 0;
  int    beats  = 0;
  int    nz     = 0;
  int    model_nz = 0;
  int    ready_pct = 100;
  beat_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference pattern straight from the mode definitions
  function automatic beat_t model_beat(int md, logic [W-1:0] pv, int ph, int s, int f);
    beat_t b;
    logic [W-1:0] re, im;
    re = '0;
    im = '0;
    case (md)
      0: if (s == ph) re = pv;
      1: if (s >= ph) re = pv;
      2: begin re = W'(s); im = W'(f); end
      default: begin re = pv; im = pv; end
    endcase
    b.data = {im, re};
    b.last = (s == N - 1);
    b.user = FW'(f);
    return b;
  endfunction

  // Sink readiness changes just after each rising edge
  initial begin
    m_axis.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_axis.tready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: handshakes against the expected queue, payload hold while stalled
  initial begin
    beat_t cur, prev;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {m_axis.tdata, m_axis_tlast, m_axis_tuser};
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (m_axis.tvalid) begin
          if (prev_stall) chk("stall_hold", 64'(cur), 64'(prev));
          if (m_axis.tready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL extra_beat got=%0h want=none", cur);
            end else begin
              chk($sformatf("beat%0d", beats), 64'(cur), 64'(exp_q.pop_front()));
            end
            beats++;
            if (m_axis.tdata[W-1:0] != '0) nz++;
          end
        end
        prev_stall = m_axis.tvalid && !m_axis.tready;
        prev = cur;
      end
    end
  end

  task automatic start_burst(int md, int pv, int ph, int nf, int mframes, int rdy);
    logic [W-1:0] pvw;
    beat_t b;
    pvw = pv[W-1:0];
    model_nz = 0;
    for (int f = 0; f < mframes; f++)
      for (int s = 0; s < N; s++) begin
        b = model_beat(md, pvw, ph, s, f);
        if (b.data[W-1:0] != '0) model_nz++;
        exp_q.push_back(b);
      end
    beats = 0;
    nz = 0;
    ready_pct = rdy;
    @(negedge clk);
    mode = md[1:0];
    pulse_val = pvw;
    impulse_phase = ph[6:0];
    num_frames = nf[FW-1:0];
    en = 1'b1;
    @(negedge clk);
    chk("start_busy_valid", {busy, m_axis.tvalid, done}, 3'b110);
  endtask

  task automatic finish_burst(int eb, int enz);
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("done_state", {done, busy, m_axis.tvalid}, 3'b100);
    chk("beat_count", beats, eb);
    chk("nonzero_re", nz, enz);
    chk("queue_empty", exp_q.size(), 0);
    en = 1'b0;
    @(negedge clk);
    chk("done_clear", {done, busy, m_axis.tvalid}, 3'b000);
  endtask

  task automatic wait_beats(int n);
    int c;
    c = 0;
    while (beats < n && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (beats < n) chk("wait_beats", beats, n);
  endtask

  vec_t tbl[8];

  initial begin
    int n;
    tbl[0] = '{md:0, pv:64,    ph:49, nf:3, rdy:100, eb:192, enz:3};
    tbl[1] = '{md:2, pv:0,     ph:0,  nf:2, rdy:50,  eb:128, enz:126};
    tbl[2] = '{md:1, pv:-300,  ph:70, nf:1, rdy:100, eb:64,  enz:0};
    tbl[3] = '{md:1, pv:1234,  ph:0,  nf:2, rdy:70,  eb:128, enz:128};
    tbl[4] = '{md:3, pv:-5,    ph:0,  nf:1, rdy:50,  eb:64,  enz:64};
    tbl[5] = '{md:0, pv:9,     ph:63, nf:1, rdy:100, eb:64,  enz:1};
    tbl[6] = '{md:0, pv:9,     ph:64, nf:1, rdy:100, eb:64,  enz:0};
    tbl[7] = '{md:1, pv:77,    ph:60, nf:1, rdy:30,  eb:64,  enz:4};

    rst_n = 1'b0;
    en = 1'b0;
    mode = 2'd0;
    pulse_val = '0;
    impulse_phase = '0;
    num_frames = '0;
    #3;
    chk("reset_outputs", {m_axis.tvalid, m_axis_tlast, m_axis.tdata, m_axis_tuser, busy, done}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {m_axis.tvalid, busy, done}, 3'b000);

    for (int i = 0; i < 8; i++) begin
      start_burst(tbl[i].md, tbl[i].pv, tbl[i].ph, tbl[i].nf, tbl[i].nf, tbl[i].rdy);
      finish_burst(tbl[i].eb, tbl[i].enz);
    end

    // Random bursts scored by the model
    for (int i = 0; i < 4; i++) begin
      int md, pv, ph, nf;
      md = $urandom_range(0, 3);
      pv = int'($urandom);
      ph = $urandom_range(0, 127);
      nf = $urandom_range(1, 3);
      start_burst(md, pv, ph, nf, nf, $urandom_range(20, 100));
      finish_burst(nf * N, model_nz);
    end

    // Continuous RAMP, en dropped around s=10: exactly one full frame
    start_burst(2, 0, 0, 0, 1, 100);
    wait_beats(10);
    en = 1'b0;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("stop_idle", {busy, m_axis.tvalid, done, m_axis_tlast}, 4'b0000);
    chk("stop_beats", beats, N);
    chk("stop_queue", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("stop_stays_idle", {busy, m_axis.tvalid}, 2'b00);

    // Asynchronous reset mid-frame, then a clean restart from s=0, tuser=0
    start_burst(0, 5, 40, 0, 1, 100);
    wait_beats(30);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("async_reset", {m_axis.tvalid, m_axis_tlast, m_axis.tdata, m_axis_tuser, busy, done}, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {m_axis.tvalid, busy}, 2'b00);
    start_burst(0, 5, 40, 1, 1, 100);
    finish_burst(64, 1);

    // Config changes during RUN are ignored until the next burst
    start_burst(3, 100, 0, 2, 2, 50);
    wait_beats(20);
    mode = 2'd2;
    pulse_val = 16'd7;
    impulse_phase = 7'd3;
    num_frames = 16'd1;
    finish_burst(128, 128);
    start_burst(2, 7, 3, 1, 1, 100);
    finish_burst(64, 63);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
